// File: rtl/gpu_mem_pkg.sv
// Shared types for the GPU memory-request path: burst request record,
// address generator state encoding and default field widths.
package gpu_mem_pkg;

  localparam int ADDR_WIDTH_DEF = 16;
  localparam int LEN_WIDTH_DEF  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [LEN_WIDTH_DEF-1:0]  len;
    logic                      down;
  } burst_req_t;

endpackage

// File: rtl/lpm_counter.sv
// Loadable up/down counter with synchronous clear, load and count enable.
// Priority: sclr > sload > cnt_en.
module lpm_counter #(
  parameter int    lpm_width     = 8,
  parameter string lpm_direction = "UP"
) (
  input  logic                 clock,
  input  logic                 sclr,
  input  logic                 sload,
  input  logic                 cnt_en,
  input  logic [lpm_width-1:0] data,
  output logic [lpm_width-1:0] q
);

  localparam bit COUNT_DOWN = (lpm_direction == "DOWN");

  logic [lpm_width-1:0] count_q;
  logic [lpm_width-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (sclr) begin
      count_d = '0;
    end else if (sload) begin
      count_d = data;
    end else if (cnt_en) begin
      count_d = COUNT_DOWN ? count_q - 1'b1 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    count_q <= count_d;
  end

  assign q = count_q;

endmodule

// File: rtl/burst_addr_gen.sv
// Burst address generator: accepts {base, length, direction} and emits one
// address per beat under valid/ready, with back-to-back burst chaining.
module burst_addr_gen
  import gpu_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF,
  parameter int STRIDE     = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic                  req_down,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(STRIDE);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    last_q, last_d;
  logic                    down_q, down_d;
  logic                    done_q, done_d;
  logic [LEN_WIDTH-1:0]    remaining;

  logic beat_hs;
  logic accept;
  logic len_zero;

  assign out_valid = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign out_addr  = addr_q;
  assign out_last  = last_q;
  assign done      = done_q;

  // A new request may ride on the final-beat handshake so bursts chain with no bubble.
  assign beat_hs   = out_valid && out_ready;
  assign req_ready = !abort && ((state_q == IDLE) || (beat_hs && last_q));
  assign accept    = req_valid && req_ready;
  assign len_zero  = (req_len == '0);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    last_d  = last_q;
    down_d  = down_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = IDLE;
      last_d  = 1'b0;
    end else begin
      // Completion of the old burst and an accepted empty burst merge into one pulse.
      done_d = (beat_hs && last_q) || (accept && len_zero);
      if (accept) begin
        if (len_zero) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end else begin
          state_d = RUN;
          addr_d  = req_addr;
          last_d  = (req_len == LEN_WIDTH'(1));
          down_d  = req_down;
        end
      end else if (beat_hs && last_q) begin
        state_d = IDLE;
        last_d  = 1'b0;
      end else if (beat_hs) begin
        addr_d = down_q ? addr_q - STEP : addr_q + STEP;
        last_d = (remaining == LEN_WIDTH'(2));
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      last_q  <= 1'b0;
      down_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      down_q  <= down_d;
      done_q  <= done_d;
    end
  end

  lpm_counter #(
    .lpm_width    (LEN_WIDTH),
    .lpm_direction("DOWN")
  ) u_beat_cnt (
    .clock (clock),
    .sclr  (abort || !reset_n),
    .sload (accept),
    .cnt_en(beat_hs),
    .data  (req_len),
    .q     (remaining)
  );

endmodule

// File: tb/tb_burst_addr_gen.sv
// Directed bench for burst_addr_gen: table of per-cycle vectors on a
// STRIDE=1 instance plus hand sequences on a STRIDE=4 instance.
module tb_burst_addr_gen;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic [15:0] req_addr;
  logic [7:0]  req_len;
  logic        req_down;
  logic        out_ready;
  logic        abort;

  logic        d1_req_ready, d1_out_valid, d1_out_last, d1_busy, d1_done;
  logic [15:0] d1_out_addr;
  logic        d4_req_ready, d4_out_valid, d4_out_last, d4_busy, d4_done;
  logic [15:0] d4_out_addr;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  burst_addr_gen #(.ADDR_WIDTH(16), .LEN_WIDTH(8), .STRIDE(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(d1_req_ready),
    .req_addr(req_addr), .req_len(req_len), .req_down(req_down),
    .out_valid(d1_out_valid), .out_ready(out_ready), .out_addr(d1_out_addr),
    .out_last(d1_out_last), .abort(abort), .busy(d1_busy), .done(d1_done)
  );

  burst_addr_gen #(.ADDR_WIDTH(16), .LEN_WIDTH(8), .STRIDE(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(d4_req_ready),
    .req_addr(req_addr), .req_len(req_len), .req_down(req_down),
    .out_valid(d4_out_valid), .out_ready(out_ready), .out_addr(d4_out_addr),
    .out_last(d4_out_last), .abort(abort), .busy(d4_busy), .done(d4_done)
  );

  typedef struct {
    logic        rst_n;
    logic        rv;
    logic [15:0] ra;
    logic [7:0]  rl;
    logic        rd;
    logic        ordy;
    logic        ab;
    logic        e_rdy;
    logic        e_vld;
    logic [15:0] e_addr;
    logic        e_last;
    logic        e_busy;
    logic        e_done;
    logic        chk_addr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst_n, rv, input logic [15:0] ra, input logic [7:0] rl,
                     input logic rd, ordy, ab, e_rdy, e_vld, input logic [15:0] e_addr,
                     input logic e_last, e_busy, e_done, chk_addr);
    vec_t v;
    v.rst_n = rst_n; v.rv = rv; v.ra = ra; v.rl = rl; v.rd = rd; v.ordy = ordy; v.ab = ab;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_addr = e_addr; v.e_last = e_last;
    v.e_busy = e_busy; v.e_done = e_done; v.chk_addr = chk_addr;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rv, input logic [15:0] ra, input logic [7:0] rl,
                       input logic rd, ordy, ab);
    @(negedge clock);
    reset_n = 1'b1; req_valid = rv; req_addr = ra; req_len = rl; req_down = rd;
    out_ready = ordy; abort = ab;
    #1;
  endtask

  initial begin
    int busy_cycles;
    reset_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0;
    req_down = 1'b0; out_ready = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clock);

    // reset state, then ascending len=4 burst at 0x0100
    add(0,0,16'h0000,0,0,0,0, 1,0,16'h0000,0,0,0,1);
    add(1,1,16'h0100,4,0,1,0, 1,0,16'h0000,0,0,0,1);
    add(1,0,16'h0000,0,0,1,0, 0,1,16'h0100,0,1,0,1);
    add(1,0,16'h0000,0,0,1,0, 0,1,16'h0101,0,1,0,1);
    add(1,0,16'h0000,0,0,1,0, 0,1,16'h0102,0,1,0,1);
    add(1,0,16'h0000,0,0,1,0, 1,1,16'h0103,1,1,0,1);
    add(1,0,16'h0000,0,0,1,0, 1,0,16'h0000,0,0,1,0);
    add(1,0,16'h0000,0,0,1,0, 1,0,16'h0000,0,0,0,0);
    // empty burst
    add(1,1,16'h1234,0,0,1,0, 1,0,16'h0000,0,0,0,0);
    add(1,0,16'h0000,0,0,1,0, 1,0,16'h0000,0,0,1,0);
    add(1,0,16'h0000,0,0,1,0, 1,0,16'h0000,0,0,0,0);
    // ascending wrap
    add(1,1,16'hFFFE,4,0,1,0, 1,0,16'h0000,0,0,0,0);
    add(1,0,16'h0000,0,0,1,0, 0,1,16'hFFFE,0,1,0,1);
    add(1,0,16'h0000,0,0,1,0, 0,1,16'hFFFF,0,1,0,1);
    add(1,0,16'h0000,0,0,1,0, 0,1,16'h0000,0,1,0,1);
    add(1,0,16'h0000,0,0,1,0, 1,1,16'h0001,1,1,0,1);
    add(1,0,16'h0000,0,0,1,0, 1,0,16'h0000,0,0,1,0);
    // back-to-back A(len2 @0x0010) then B(len1 @0x0200)
    add(1,1,16'h0010,2,0,1,0, 1,0,16'h0000,0,0,0,0);
    add(1,1,16'h0200,1,0,1,0, 0,1,16'h0010,0,1,0,1);
    add(1,1,16'h0200,1,0,1,0, 1,1,16'h0011,1,1,0,1);
    add(1,0,16'h0000,0,0,1,0, 1,1,16'h0200,1,1,1,1);
    add(1,0,16'h0000,0,0,1,0, 1,0,16'h0000,0,0,1,0);
    // chained empty burst on the last beat: single merged done
    add(1,1,16'h0300,1,0,1,0, 1,0,16'h0000,0,0,0,0);
    add(1,1,16'h0777,0,0,1,0, 1,1,16'h0300,1,1,0,1);
    add(1,0,16'h0000,0,0,1,0, 1,0,16'h0000,0,0,1,0);
    add(1,0,16'h0000,0,0,1,0, 1,0,16'h0000,0,0,0,0);
    // abort on second beat, with a competing request
    add(1,1,16'h4000,8,0,1,0, 1,0,16'h0000,0,0,0,0);
    add(1,0,16'h0000,0,0,1,0, 0,1,16'h4000,0,1,0,1);
    add(1,1,16'h9999,3,0,1,1, 0,1,16'h4001,0,1,0,1);
    add(1,0,16'h0000,0,0,1,0, 1,0,16'h0000,0,0,0,0);
    add(1,0,16'h0000,0,0,1,0, 1,0,16'h0000,0,0,0,0);
    // reset mid-burst
    add(1,1,16'h5000,8,0,1,0, 1,0,16'h0000,0,0,0,0);
    add(1,0,16'h0000,0,0,1,0, 0,1,16'h5000,0,1,0,1);
    add(0,0,16'h0000,0,0,1,0, 0,1,16'h5001,0,1,0,1);
    add(0,0,16'h0000,0,0,1,0, 1,0,16'h0000,0,0,0,1);
    add(1,0,16'h0000,0,0,0,0, 1,0,16'h0000,0,0,0,1);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clock);
      reset_n = tbl[i].rst_n; req_valid = tbl[i].rv; req_addr = tbl[i].ra;
      req_len = tbl[i].rl; req_down = tbl[i].rd; out_ready = tbl[i].ordy; abort = tbl[i].ab;
      #1;
      chk($sformatf("v%0d req_ready", i), 32'(d1_req_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("v%0d out_valid", i), 32'(d1_out_valid), 32'(tbl[i].e_vld));
      chk($sformatf("v%0d out_last", i),  32'(d1_out_last),  32'(tbl[i].e_last));
      chk($sformatf("v%0d busy", i),      32'(d1_busy),      32'(tbl[i].e_busy));
      chk($sformatf("v%0d done", i),      32'(d1_done),      32'(tbl[i].e_done));
      if (tbl[i].chk_addr)
        chk($sformatf("v%0d out_addr", i), 32'(d1_out_addr), 32'(tbl[i].e_addr));
    end

    // STRIDE=4 descending burst with out_ready toggling 1,0,1,0,1
    busy_cycles = 0;
    drive(1,16'h0008,3,1,1,0);
    chk("s4 accept ready", 32'(d4_req_ready), 32'd1);
    drive(0,16'h0000,0,0,1,0); busy_cycles += int'(d4_busy);
    chk("s4 beat0 addr", 32'(d4_out_addr), 32'h0008);
    chk("s4 beat0 valid", 32'(d4_out_valid), 32'd1);
    drive(0,16'h0000,0,0,0,0); busy_cycles += int'(d4_busy);
    chk("s4 beat1 addr", 32'(d4_out_addr), 32'h0004);
    drive(0,16'h0000,0,0,1,0); busy_cycles += int'(d4_busy);
    chk("s4 beat1 held addr", 32'(d4_out_addr), 32'h0004);
    chk("s4 beat1 held last", 32'(d4_out_last), 32'd0);
    drive(0,16'h0000,0,0,0,0); busy_cycles += int'(d4_busy);
    chk("s4 beat2 addr", 32'(d4_out_addr), 32'h0000);
    chk("s4 beat2 last", 32'(d4_out_last), 32'd1);
    drive(0,16'h0000,0,0,1,0); busy_cycles += int'(d4_busy);
    chk("s4 beat2 held addr", 32'(d4_out_addr), 32'h0000);
    chk("s4 beat2 ready", 32'(d4_req_ready), 32'd1);
    drive(0,16'h0000,0,0,1,0); busy_cycles += int'(d4_busy);
    chk("s4 done", 32'(d4_done), 32'd1);
    chk("s4 idle valid", 32'(d4_out_valid), 32'd0);
    chk("s4 run cycles", 32'(busy_cycles), 32'd5);

    // STRIDE=4 descending wrap from 0; req_down flipped mid-burst is ignored
    drive(1,16'h0000,2,1,1,0);
    drive(0,16'h0000,0,0,1,0);
    chk("s4 wrap beat0", 32'(d4_out_addr), 32'h0000);
    drive(0,16'h0000,0,0,1,0);
    chk("s4 wrap beat1", 32'(d4_out_addr), 32'hFFFC);
    chk("s4 wrap last", 32'(d4_out_last), 32'd1);
    drive(0,16'h0000,0,0,1,0);
    chk("s4 wrap done", 32'(d4_done), 32'd1);
    drive(0,16'h0000,0,0,1,0);
    chk("s4 wrap done pulse", 32'(d4_done), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/burst_addr_gen.md
Name: burst_addr_gen

Overview:
Sequential address generator that turns one burst request (base, length, direction) into a stream of per-beat addresses under valid/ready flow control. It sits directly upstream of the GPU memory-request path and drives counter-style sload/cnt_en control internally. It supplies the fetch and store units with bursts of consecutive word addresses. It also makes the counter's load/count/wrap semantics available behind a handshake interface.

Parameters:
ADDR_WIDTH, 16, width of base and output address; addresses wrap modulo 2^ADDR_WIDTH.
LEN_WIDTH, 8, width of burst length field; max burst = 2^LEN_WIDTH-1 beats.
STRIDE, 1, address increment/decrement per beat (unsigned, < 2^ADDR_WIDTH).

Ports:
clock  input  1  rising-edge clock, sole clock domain.
reset_n  input  1  synchronous active-low reset.
req_valid  input  1  burst request present.
req_ready  output  1  generator can accept a request this cycle.
req_addr  input  ADDR_WIDTH  first beat address.
req_len  input  LEN_WIDTH  number of beats; 0 = empty burst.
req_down  input  1  0 = ascending addresses, 1 = descending.
out_valid  output  1  out_addr holds a valid beat.
out_ready  input  1  consumer accepts the beat.
out_addr  output  ADDR_WIDTH  current beat address.
out_last  output  1  current beat is the final beat of the burst.
abort  input  1  synchronous flush of the active burst.
busy  output  1  burst in progress (state RUN).
done  output  1  one-cycle pulse after a burst completes or an empty burst is accepted.

Behaviour:
- Reset (reset_n=0 at clock edge):
  - State goes to IDLE.
  - out_valid=0, out_addr=0, out_last=0, busy=0, done=0.
  - Internal beat count=0.
  - Reset wins over every other input.
- States:
  - IDLE: req_ready=1, out_valid=0.
  - RUN: out_valid=1, busy=1.
- Request acceptance: req_valid && req_ready at the clock edge.
  - req_len=0: stay IDLE, no beats; done=1 next cycle.
  - req_len>0: go to RUN next cycle; out_addr=req_addr, remaining=req_len, out_last=(req_len==1).
  - Latency: first beat is visible one cycle after acceptance.
- Beat handshake: out_valid && out_ready at the clock edge.
  - Not last: out_addr advances by +STRIDE (req_down=0) or -STRIDE (req_down=1), modulo 2^ADDR_WIDTH; remaining decrements; out_last=(remaining==2 before decrement).
  - Last: burst completes; done=1 next cycle.
- Stall: out_valid && !out_ready → out_addr, out_last and remaining hold exactly.
- Back-to-back bursts:
  - In RUN, req_ready = out_valid && out_ready && out_last, which is combinational from out_ready.
  - If a new request is accepted on the last-beat handshake, the next cycle shows the new burst's first beat (no idle bubble), and done still pulses for the finished burst.
  - If that new request has req_len=0: go IDLE; done pulses once (coincident completions merge into one pulse).
- Direction is latched at acceptance; req_down is ignored mid-burst.
- Wrap:
  - ascending from 2^ADDR_WIDTH-STRIDE gives 0;
  - descending from 0 gives 2^ADDR_WIDTH-STRIDE.
  - No error flag on wrap.
- abort (synchronous, priority below reset, above everything else):
  - Next cycle: IDLE, out_valid=0, out_last=0, done=0.
  - Any request presented in the same cycle is not accepted (req_ready forced 0 while abort=1).
  - A beat handshake coinciding with abort is considered not consumed.
- Output rules:
  - out_addr and out_last are registered.
  - busy equals (state==RUN).
  - done is a registered pulse, never high for two consecutive cycles from one burst.

Decomposition:
- Shared package gpu_mem_pkg holds:
  - state enum {IDLE, RUN};
  - ADDR_WIDTH and LEN_WIDTH defaults;
  - a packed burst_req_t {addr, len, down} used by both producers and this block.
- One sub-module is natural: the existing lpm_counter, instanced as the beat counter.
  - Settings: lpm_width=LEN_WIDTH, lpm_direction="DOWN".
  - sload on acceptance, cnt_en on beat handshake, sclr on abort.
  - Its q drives remaining.
- The address register stays local because STRIDE is not 1 in general.

Test Plan:
- Reset then req addr=0x0100, len=4, up, out_ready=1 → out_addr 0x0100,0x0101,0x0102,0x0103 on consecutive cycles; out_last only on 0x0103; done pulse the following cycle.
- STRIDE=4, req addr=0x0008, len=3, down, out_ready toggling 1,0,1,0,1 → addresses 0x0008,0x0004,0x0000, each held while stalled; total 5 cycles in RUN.
- Wrap: addr=0xFFFE, len=4, up, STRIDE=1 → 0xFFFE,0xFFFF,0x0000,0x0001.
- Back-to-back: burst A len=2 at 0x0010, burst B len=1 at 0x0200 presented continuously → 0x0010,0x0011,0x0200 with no bubble; done pulses after A and after B.
- req len=0 → no out_valid; done=1 exactly one cycle after acceptance; req_ready stays 1.
- abort on the second beat of len=8 with out_ready=1 → out_valid=0 next cycle, no done, busy=0; reset_n=0 mid-burst → all outputs 0 next cycle.
